// File: rtl/instr_encoder.sv
// Serializes decoded scene commands into the 32-bit instruction word stream.
// Define INSTR_ENCODER_STATS_EN to add word/unsupported statistics counters.
module instr_encoder #(
    parameter logic [1:0] FRAME_FUNC = 2'b01,
    parameter int         STAT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_type,
    input  logic [4:0]        cmd_prop,
    input  logic [4:0]        cmd_prop2,
    input  logic [5:0]        cmd_lindex,
    input  logic [18:0]       cmd_sindex,
    input  logic [4:0]        cmd_stype,
    input  logic [15:0]       cmd_data,
    input  logic [15:0]       cmd_data2,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instruction,
`ifdef INSTR_ENCODER_STATS_EN
    output logic [STAT_W-1:0] words_emitted,
    output logic [STAT_W-1:0] unsupported_count,
`endif
    output logic              busy,
    output logic              err_unsupported
);

    localparam logic [2:0] OC_F_TYPE  = 3'd0;
    localparam logic [2:0] OC_C_TYPE  = 3'd1;
    localparam logic [2:0] OC_L_TYPE  = 3'd2;
    localparam logic [2:0] OC_SI_TYPE = 3'd3;
    localparam logic [2:0] OC_SE_TYPE = 3'd4;

    typedef enum logic [1:0] {IDLE, STREAM, SE_HEAD, SE_DATA} state_t;

    state_t      state_p0, state_n;
    logic [31:0] instr_p0, instr_n;
    logic [31:0] hold_p0, hold_n;
    logic        vld_p0, vld_n;
    logic        err_p0, err_n;
    logic        accept, word_hs;

    function automatic logic [31:0] sindex_word(input logic [2:0] op, input logic [18:0] sidx);
        logic [31:0] w;
        w        = '0;
        w[2:0]   = op;
        w[5:3]   = sidx[2:0];
        w[31:16] = sidx[18:3];
        return w;
    endfunction

    assign cmd_ready       = (state_p0 != SE_HEAD) && (!vld_p0 || instr_ready);
    assign accept          = cmd_valid && cmd_ready;
    assign word_hs         = vld_p0 && instr_ready;
    assign instr_valid     = vld_p0;
    assign instruction     = instr_p0;
    assign err_unsupported = err_p0;
    assign busy            = vld_p0 || (state_p0 == SE_HEAD);

    always_comb begin
        state_n = state_p0;
        instr_n = instr_p0;
        hold_n  = hold_p0;
        vld_n   = vld_p0;
        err_n   = 1'b0;
        if (state_p0 == SE_HEAD) begin
            // Header taken: the shape-data word follows with valid held high
            if (word_hs) begin
                instr_n = hold_p0;
                state_n = SE_DATA;
            end
        end else begin
            if (word_hs) begin
                vld_n   = 1'b0;
                state_n = IDLE;
            end
            if (accept) begin
                case (cmd_type)
                    3'd0: begin
                        instr_n = {29'd0, OC_F_TYPE};
                        vld_n   = 1'b1;
                        state_n = STREAM;
                    end
                    3'd1: begin
                        instr_n        = {29'd0, OC_F_TYPE};
                        instr_n[10:9]  = FRAME_FUNC;
                        vld_n          = 1'b1;
                        state_n        = STREAM;
                    end
                    3'd2: begin
                        instr_n = {cmd_data, cmd_prop, 8'd0, OC_C_TYPE};
                        vld_n   = 1'b1;
                        state_n = STREAM;
                    end
                    3'd3: begin
                        instr_n = {cmd_data, cmd_prop, 2'd0, cmd_lindex, OC_L_TYPE};
                        vld_n   = 1'b1;
                        state_n = STREAM;
                    end
                    3'd4: begin
                        instr_n        = sindex_word(OC_SI_TYPE, cmd_sindex);
                        instr_n[15:11] = cmd_stype;
                        vld_n          = 1'b1;
                        state_n        = STREAM;
                    end
                    3'd5: begin
                        instr_n        = sindex_word(OC_SE_TYPE, cmd_sindex);
                        instr_n[15:11] = cmd_prop;
                        instr_n[10:6]  = cmd_prop2;
                        hold_n         = {cmd_data, cmd_data2};
                        vld_n          = 1'b1;
                        state_n        = SE_HEAD;
                    end
                    default: err_n = 1'b1;
                endcase
            end
        end
    end

    // Output stage: control and the visible word are cleared on reset
    always_ff @(posedge clk) begin
        hold_p0 <= hold_n;
        if (rst) begin
            state_p0 <= IDLE;
            instr_p0 <= '0;
            vld_p0   <= 1'b0;
            err_p0   <= 1'b0;
        end else begin
            state_p0 <= state_n;
            instr_p0 <= instr_n;
            vld_p0   <= vld_n;
            err_p0   <= err_n;
        end
    end

`ifdef INSTR_ENCODER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            words_emitted     <= '0;
            unsupported_count <= '0;
        end else begin
            if (word_hs)
                words_emitted <= words_emitted + 1'b1;
            if (err_n)
                unsupported_count <= unsupported_count + 1'b1;
        end
    end
`endif

endmodule
